xor_parity_unit: RTL



---
 rtl/xor_parity_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/xor_parity_unit.sv
// Frame-wise XOR accumulator on a valid/ready stream. At end of frame it presents the
// column parity, its reduction bit, the word count, and the check-mode error and overflow flags.
module xor_parity_unit #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_WORDS = 16,
  localparam int unsigned CW       = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_parity,
  output logic             out_bit,
  output logic [CW-1:0]    out_count,
  output logic             out_err,
  output logic             out_ovf
);

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;

  logic [WIDTH-1:0] par_q, par_d;
  logic             bit_q, bit_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  logic             beat;
  logic             first;
  logic             term;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             mode_nxt;

  assign beat  = in_valid && in_ready;
  assign first = (state_q == StIdle);

  // Running values including the current beat; the first beat of a frame restarts them.
  assign acc_nxt  = first ? in_data : (acc_q ^ in_data);
  assign cnt_nxt  = first ? CW'(1) : (cnt_q + CW'(1));
  assign mode_nxt = first ? mode : mode_q;

  // A frame ends on in_last or when the word budget is used up.
  assign term = beat && (in_last || (cnt_nxt == CW'(MAX_WORDS)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (beat) begin
          state_d = term ? StHold : StAcc;
        end
      end
      StAcc: begin
        if (term) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic; in_ready is held low throughout reset.
  always_comb begin
    in_ready  = rst_n && (state_q != StHold);
    out_valid = (state_q == StHold);
  end

  // Accumulator datapath
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (beat) begin
      acc_d  = acc_nxt;
      cnt_d  = cnt_nxt;
      mode_d = mode_nxt;
    end
  end

  // Result registers load only on the terminating beat, so they stay stable through HOLD.
  always_comb begin
    par_d   = par_q;
    bit_d   = bit_q;
    count_d = count_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    if (term) begin
      par_d   = acc_nxt;
      bit_d   = ^acc_nxt;
      count_d = cnt_nxt;
      err_d   = mode_nxt && (acc_nxt != '0);
      ovf_d   = !in_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      par_q   <= '0;
      bit_q   <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      count_q <= count_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_parity = par_q;
  assign out_bit    = bit_q;
  assign out_count  = count_q;
  assign out_err    = err_q;
  assign out_ovf    = ovf_q;

`ifndef SYNTHESIS
  cnt_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CW'(MAX_WORDS));

  hold_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid && !out_ready |=> out_valid && $stable(par_q) && $stable(count_q)
                                && $stable(err_q) && $stable(ovf_q));
`endif

endmodule
